// File: rtl/pkt_gen_pkg.sv
// Shared types, sizes and the payload length clamp for the AXI4-Stream frame generator.
package pkt_gen_pkg;

  localparam int unsigned DATA_W          = 8;
  localparam int unsigned LEN_W           = 11;
  localparam int unsigned FC_W            = 16;
  localparam int unsigned HDR_IDX_W       = 4;
  localparam int unsigned HDR_LEN         = 14;
  localparam int unsigned DEF_MIN_PAYLOAD = 46;
  localparam int unsigned DEF_MAX_PAYLOAD = 1500;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_HDR,
    ST_PAYLOAD,
    ST_GAP
  } state_e;

  // Limit a requested payload length to the range [lo, hi].
  function automatic logic [LEN_W-1:0] clamp_len(input logic [LEN_W-1:0] len,
                                                 input int unsigned lo,
                                                 input int unsigned hi);
    logic [LEN_W-1:0] res;
    res = len;
    if (32'(len) < lo) begin
      res = LEN_W'(lo);
    end else if (32'(len) > hi) begin
      res = LEN_W'(hi);
    end
    return res;
  endfunction

endpackage

// File: rtl/pkt_gen_hdr_sel.sv
// Header byte lookup: maps a header byte index (0..13) to DA, SA or length-field bytes.
module pkt_gen_hdr_sel
  import pkt_gen_pkg::*;
#(
  parameter logic [47:0] DST_MAC = 48'hFFFF_FFFF_FFFF,
  parameter logic [47:0] SRC_MAC = 48'h000A_3501_0203
) (
  input  logic [HDR_IDX_W-1:0] idx,
  input  logic [LEN_W-1:0]     len,
  output logic [DATA_W-1:0]    hdr_byte_c
);

  logic [8*HDR_LEN-1:0] hdr_vec;

  // Header laid out MSB first so byte i sits at the top minus i bytes.
  assign hdr_vec = {DST_MAC, SRC_MAC, 16'(len)};

  // Select the indexed byte; out-of-range indices read as zero.
  always_comb begin
    hdr_byte_c = '0;
    for (int unsigned i = 0; i < HDR_LEN; i++) begin
      if (idx == HDR_IDX_W'(i)) begin
        hdr_byte_c = hdr_vec[8*(HDR_LEN-1-i) +: 8];
      end
    end
  end

endmodule

// File: rtl/axi4_st_pkt_gen.sv
// Registered AXI4-Stream Ethernet frame generator: header + counting payload, bursts or continuous.
module axi4_st_pkt_gen
  import pkt_gen_pkg::*;
#(
  parameter logic [47:0] DST_MAC     = 48'hFFFF_FFFF_FFFF,
  parameter logic [47:0] SRC_MAC     = 48'h000A_3501_0203,
  parameter int unsigned IFG_CYCLES  = 12,
  parameter int unsigned MIN_PAYLOAD = DEF_MIN_PAYLOAD,
  parameter int unsigned MAX_PAYLOAD = DEF_MAX_PAYLOAD
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              start,
  input  logic              stop,
  input  logic [FC_W-1:0]   frame_count,
  input  logic [LEN_W-1:0]  payload_len,
  output logic              busy,
  output logic [FC_W-1:0]   frames_sent,
  output logic [DATA_W-1:0] tdata,
  output logic              tvalid,
  output logic              tlast,
  output logic              tuser,
  input  logic              tready
);

  localparam int unsigned GAP_W = (IFG_CYCLES > 1) ? $clog2(IFG_CYCLES) : 1;
  localparam logic [HDR_IDX_W-1:0] HDR_LAST = HDR_IDX_W'(HDR_LEN - 1);
  localparam logic [GAP_W-1:0]     GAP_LAST = GAP_W'(IFG_CYCLES - 1);

  state_e                state_q, state_d;
  logic [HDR_IDX_W-1:0]  hdr_idx_q, hdr_idx_d;
  logic [LEN_W-1:0]      pay_idx_q, pay_idx_d;
  logic [GAP_W-1:0]      gap_cnt_q, gap_cnt_d;
  logic [LEN_W-1:0]      len_q, len_d;
  logic [FC_W-1:0]       fc_q, fc_d;
  logic [FC_W-1:0]       frames_sent_q, frames_sent_d;
  logic                  stop_req_q, stop_req_d;
  logic [DATA_W-1:0]     tdata_q, tdata_d;
  logic                  tvalid_q, tvalid_d;
  logic                  tlast_q, tlast_d;
  logic                  tuser_q, tuser_d;
  logic                  busy_q, busy_d;

  logic [HDR_IDX_W-1:0]  hdr_sel_idx_c;
  logic [DATA_W-1:0]     hdr_byte_c;
  logic                  beat_done_c;

  assign beat_done_c   = tvalid_q & tready;
  // Look ahead to the header byte that will be presented after the current one.
  assign hdr_sel_idx_c = (state_q == ST_HDR) ? hdr_idx_q + HDR_IDX_W'(1) : '0;

  pkt_gen_hdr_sel #(
    .DST_MAC (DST_MAC),
    .SRC_MAC (SRC_MAC)
  ) u_hdr_sel (
    .idx        (hdr_sel_idx_c),
    .len        (len_q),
    .hdr_byte_c (hdr_byte_c)
  );

  // Next-state and next-beat logic; output flops load the beat that follows each transfer.
  always_comb begin
    state_d       = state_q;
    hdr_idx_d     = hdr_idx_q;
    pay_idx_d     = pay_idx_q;
    gap_cnt_d     = gap_cnt_q;
    len_d         = len_q;
    fc_d          = fc_q;
    frames_sent_d = frames_sent_q;
    stop_req_d    = stop_req_q;
    tdata_d       = tdata_q;
    tvalid_d      = tvalid_q;
    tlast_d       = tlast_q;
    tuser_d       = 1'b0;
    busy_d        = busy_q;

    case (state_q)
      ST_IDLE: begin
        if (start) begin
          len_d         = clamp_len(payload_len, MIN_PAYLOAD, MAX_PAYLOAD);
          fc_d          = frame_count;
          frames_sent_d = '0;
          stop_req_d    = 1'b0;
          state_d       = ST_HDR;
          hdr_idx_d     = '0;
          tvalid_d      = 1'b1;
          tdata_d       = hdr_byte_c;
          tlast_d       = 1'b0;
        end
      end

      ST_HDR: begin
        stop_req_d = stop_req_q | stop;
        if (beat_done_c) begin
          if (hdr_idx_q == HDR_LAST) begin
            state_d   = ST_PAYLOAD;
            pay_idx_d = '0;
            tdata_d   = frames_sent_q[DATA_W-1:0];
            tlast_d   = (len_q == LEN_W'(1));
          end else begin
            hdr_idx_d = hdr_idx_q + HDR_IDX_W'(1);
            tdata_d   = hdr_byte_c;
          end
        end
      end

      ST_PAYLOAD: begin
        stop_req_d = stop_req_q | stop;
        if (beat_done_c) begin
          if (tlast_q) begin
            frames_sent_d = frames_sent_q + FC_W'(1);
            state_d       = ST_GAP;
            gap_cnt_d     = '0;
            tvalid_d      = 1'b0;
            tlast_d       = 1'b0;
            tdata_d       = '0;
          end else begin
            pay_idx_d = pay_idx_q + LEN_W'(1);
            tdata_d   = frames_sent_q[DATA_W-1:0] + pay_idx_d[DATA_W-1:0];
            tlast_d   = (pay_idx_d == len_q - LEN_W'(1));
          end
        end
      end

      ST_GAP: begin
        stop_req_d = stop_req_q | stop;
        if (gap_cnt_q == GAP_LAST) begin
          if (stop_req_d || ((fc_q != '0) && (frames_sent_q == fc_q))) begin
            state_d = ST_IDLE;
          end else begin
            state_d   = ST_HDR;
            hdr_idx_d = '0;
            tvalid_d  = 1'b1;
            tdata_d   = hdr_byte_c;
            tlast_d   = 1'b0;
          end
        end else begin
          gap_cnt_d = gap_cnt_q + GAP_W'(1);
        end
      end

      default: begin
        state_d = ST_IDLE;
      end
    endcase

    busy_d = (state_d != ST_IDLE);
  end

  // State and output registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q       <= ST_IDLE;
      hdr_idx_q     <= '0;
      pay_idx_q     <= '0;
      gap_cnt_q     <= '0;
      len_q         <= '0;
      fc_q          <= '0;
      frames_sent_q <= '0;
      stop_req_q    <= 1'b0;
      tdata_q       <= '0;
      tvalid_q      <= 1'b0;
      tlast_q       <= 1'b0;
      tuser_q       <= 1'b0;
      busy_q        <= 1'b0;
    end else begin
      state_q       <= state_d;
      hdr_idx_q     <= hdr_idx_d;
      pay_idx_q     <= pay_idx_d;
      gap_cnt_q     <= gap_cnt_d;
      len_q         <= len_d;
      fc_q          <= fc_d;
      frames_sent_q <= frames_sent_d;
      stop_req_q    <= stop_req_d;
      tdata_q       <= tdata_d;
      tvalid_q      <= tvalid_d;
      tlast_q       <= tlast_d;
      tuser_q       <= tuser_d;
      busy_q        <= busy_d;
    end
  end

  assign busy        = busy_q;
  assign frames_sent = frames_sent_q;
  assign tdata       = tdata_q;
  assign tvalid      = tvalid_q;
  assign tlast       = tlast_q;
  assign tuser       = tuser_q;

endmodule
